wb2axis: RTL and testbench

Wishbone-writable transmit FIFO that turns CPU byte writes into an AXI4-Stream byte stream with packet framing (`tlast`). It is the outbound counterpart of the existing AXI-Stream-to-Wishbone bridge: it sits on the SERV data bus behind the SoC address mux, is selected by its own `stb`, and lets firmware emit framed packets towards a downstream stream sink. An internal DEPTH-entry FIFO decouples the bit-serial CPU from sink backpressure.

---
 rtl/wb2axis_if.sv | 46 ++++
 rtl/wb2axis.sv | 148 ++++++++++++++
 tb/tb_wb2axis.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/wb2axis_if.sv
// wb2axis_if: bundles the Wishbone register port and the AXI4-Stream byte
// port of the wb2axis transmit FIFO.
//   Wishbone : i_wb_sel (0=DATA, 1=CTRL), i_wb_stb, i_wb_we, i_wb_dat[9:0],
//              o_wb_rdt[9:0] (STATUS), o_wb_ack
//   Stream   : o_tdata[7:0], o_tlast, o_tvalid, i_tready
// The i_/o_ prefixes are from the bridge's point of view.
//   slave  : the bridge side (takes Wishbone requests, sources the stream)
//   master : the CPU / bus-fabric and stream-sink side
interface wb2axis_if;
    logic       i_wb_sel;
    logic       i_wb_stb;
    logic       i_wb_we;
    logic [9:0] i_wb_dat;
    logic [9:0] o_wb_rdt;
    logic       o_wb_ack;
    logic [7:0] o_tdata;
    logic       o_tlast;
    logic       o_tvalid;
    logic       i_tready;

    modport slave (
        input  i_wb_sel,
        input  i_wb_stb,
        input  i_wb_we,
        input  i_wb_dat,
        output o_wb_rdt,
        output o_wb_ack,
        output o_tdata,
        output o_tlast,
        output o_tvalid,
        input  i_tready
    );

    modport master (
        output i_wb_sel,
        output i_wb_stb,
        output i_wb_we,
        output i_wb_dat,
        input  o_wb_rdt,
        input  o_wb_ack,
        input  o_tdata,
        input  o_tlast,
        input  o_tvalid,
        output i_tready
    );
endinterface

// File: rtl/wb2axis.sv
// wb2axis: Wishbone-writable transmit FIFO feeding an AXI4-Stream byte
// stream with per-entry tlast framing.
//   i_clk  : clock
//   i_rst  : synchronous active-high reset
//   bus    : wb2axis_if.slave (Wishbone DATA/CTRL/STATUS + stream source)
// Registers:
//   DATA  write : push {dat[8] as tlast, dat[7:0] as tdata}; a push into a
//                 full FIFO is dropped and sets the sticky OVF flag.
//   CTRL  write : bit0 clears OVF, bit1 flushes the FIFO.
//   any read    : STATUS = {OVF, full, empty, 0.., level}, snapshot taken
//                 before the accepting edge updates anything.
module wb2axis #(
    parameter int DEPTH = 4
) (
    input  logic      i_clk,
    input  logic      i_rst,
    wb2axis_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    // FIFO storage: {tlast, tdata}
    logic [8:0]    mem_q [DEPTH];

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q,  level_d;
    logic          ovf_q,    ovf_d;
    logic          ack_q,    ack_d;
    logic [9:0]    rdt_q,    rdt_d;
    // Set once the current stb assertion has been accepted, so a strobe held
    // past its ack does not start a second access.
    logic          held_q,   held_d;

    logic          accept_s;
    logic          data_wr_s;
    logic          ctrl_wr_s;
    logic          push_s;
    logic          pop_s;
    logic          flush_s;
    logic          clr_ovf_s;
    logic          full_s;
    logic          empty_s;
    logic [9:0]    status_s;

    // Bit 9 of the write data has no function in either register.
    logic          unused_dat_s;
    assign unused_dat_s = bus.i_wb_dat[9];

    // Decode of the Wishbone access and FIFO occupancy flags.
    always_comb begin
        full_s    = (level_q == LW'(DEPTH));
        empty_s   = (level_q == {LW{1'b0}});
        accept_s  = bus.i_wb_stb & ~ack_q & ~held_q;
        data_wr_s = accept_s & bus.i_wb_we & ~bus.i_wb_sel;
        ctrl_wr_s = accept_s & bus.i_wb_we &  bus.i_wb_sel;
        // Full is judged on the pre-edge level, before any same-cycle pop.
        push_s    = data_wr_s & ~full_s;
        pop_s     = ~empty_s & bus.i_tready;
        flush_s   = ctrl_wr_s & bus.i_wb_dat[1];
        clr_ovf_s = ctrl_wr_s & bus.i_wb_dat[0];
        status_s  = {ovf_q, full_s, empty_s, 7'd0} | {{(10 - LW){1'b0}}, level_q};
    end

    // Next-state computation for pointers, level, flags and bus responses.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        ovf_d    = ovf_q;
        ack_d    = accept_s;
        rdt_d    = rdt_q;
        held_d   = bus.i_wb_stb & (held_q | accept_s);

        if (flush_s) begin
            // Flush wins over a same-cycle pop; the popped byte is discarded.
            wr_ptr_d = {AW{1'b0}};
            rd_ptr_d = {AW{1'b0}};
            level_d  = {LW{1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_d = wr_ptr_q + AW'(1'b1);
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (pop_s) begin
                rd_ptr_d = rd_ptr_q + AW'(1'b1);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            case ({push_s, pop_s})
                2'b10:   level_d = level_q + LW'(1'b1);
                2'b01:   level_d = level_q - LW'(1'b1);
                default: level_d = level_q;
            endcase
        end

        if (clr_ovf_s) begin
            ovf_d = 1'b0;
        end else if (data_wr_s & full_s) begin
            ovf_d = 1'b1;
        end else begin
            ovf_d = ovf_q;
        end

        if (accept_s & ~bus.i_wb_we) begin
            rdt_d = status_s;
        end else begin
            rdt_d = rdt_q;
        end
    end

    // Control and status state register with synchronous reset.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wr_ptr_q <= {AW{1'b0}};
            rd_ptr_q <= {AW{1'b0}};
            level_q  <= {LW{1'b0}};
            ovf_q    <= 1'b0;
            ack_q    <= 1'b0;
            rdt_q    <= 10'd0;
            held_q   <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            ovf_q    <= ovf_d;
            ack_q    <= ack_d;
            rdt_q    <= rdt_d;
            held_q   <= held_d;
        end
    end

    // FIFO storage write; contents need no reset since the read side is
    // gated by the level.
    always_ff @(posedge i_clk) begin
        if (push_s) begin
            mem_q[wr_ptr_q] <= {bus.i_wb_dat[8], bus.i_wb_dat[7:0]};
        end
    end

    assign bus.o_wb_ack = ack_q;
    assign bus.o_wb_rdt = rdt_q;
    assign bus.o_tvalid = ~empty_s;
    // Head entry is forced to zero while empty so the stream reads 0 out of reset.
    assign bus.o_tdata  = empty_s ? 8'h00 : mem_q[rd_ptr_q][7:0];
    assign bus.o_tlast  = empty_s ? 1'b0  : mem_q[rd_ptr_q][8];
endmodule

// File: tb/tb_wb2axis.sv
// Testbench for wb2axis (DEPTH=4): a queue-based reference model tracks the
// FIFO contents, OVF flag and expected Wishbone responses; a compare process
// checks the DUT against it on every falling edge, and directed sequences
// pin the model with hand-computed STATUS values and stream contents.
module tb_wb2axis;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    wb2axis_if bus ();

    wb2axis #(.DEPTH(DEPTH)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus.slave)
    );

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [8:0] mq[$];
    bit         m_on   = 1'b0;
    bit         m_ovf;
    bit         m_ack;
    bit         m_held;
    logic [9:0] m_rdt;
    bit         t_acc;
    bit         t_full;
    bit         t_push;
    logic [9:0] t_st;

    always @(posedge clk) begin
        if (rst) begin
            mq.delete();
            m_ovf  = 1'b0;
            m_ack  = 1'b0;
            m_held = 1'b0;
            m_rdt  = 10'd0;
            m_on   = 1'b1;
        end else if (m_on) begin
            // One access per strobe assertion.
            t_acc  = bus.i_wb_stb && !m_held;
            t_full = (mq.size() == DEPTH);
            t_st   = 10'((m_ovf ? 512 : 0) + (t_full ? 256 : 0) +
                         (mq.size() == 0 ? 128 : 0) + mq.size());
            t_push = 1'b0;
            if (mq.size() > 0 && bus.i_tready) void'(mq.pop_front());
            if (t_acc && bus.i_wb_we) begin
                if (!bus.i_wb_sel) begin
                    if (t_full) m_ovf = 1'b1;
                    else        t_push = 1'b1;
                end else begin
                    if (bus.i_wb_dat[0]) m_ovf = 1'b0;
                    if (bus.i_wb_dat[1]) mq.delete();
                end
            end
            if (t_push) mq.push_back(bus.i_wb_dat[8:0]);
            if (t_acc && !bus.i_wb_we) m_rdt = t_st;
            m_ack  = t_acc;
            m_held = bus.i_wb_stb && (m_held || t_acc);
        end
    end

    // ---------------- stream log and hold tracking ----------------
    logic [8:0] got[$];
    bit         hold_prev = 1'b0;
    logic [8:0] data_prev;

    always @(posedge clk) begin
        hold_prev = !rst && bus.o_tvalid && !bus.i_tready;
        data_prev = {bus.o_tlast, bus.o_tdata};
        if (!rst && bus.o_tvalid && bus.i_tready) got.push_back({bus.o_tlast, bus.o_tdata});
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (m_on) begin
            chk("ack", {31'd0, bus.o_wb_ack}, {31'd0, m_ack});
            chk("rdt", {22'd0, bus.o_wb_rdt}, {22'd0, m_rdt});
            chk("tvalid", {31'd0, bus.o_tvalid}, {31'd0, mq.size() != 0});
            if (mq.size() != 0) begin
                chk("tdata", {24'd0, bus.o_tdata}, {24'd0, mq[0][7:0]});
                chk("tlast", {31'd0, bus.o_tlast}, {31'd0, mq[0][8]});
            end
            if (hold_prev && bus.o_tvalid)
                chk("stable", {23'd0, bus.o_tlast, bus.o_tdata}, {23'd0, data_prev});
        end
    end

    // ---------------- ready toggler ----------------
    bit toggle_en = 1'b0;
    always @(negedge clk) begin
        if (toggle_en) bus.i_tready = ~bus.i_tready;
    end

    // ---------------- drivers ----------------
    task automatic wb_acc(input logic sel, input logic we, input logic [9:0] dat,
                          output logic [9:0] rd);
        int n;
        @(negedge clk);
        bus.i_wb_sel = sel;
        bus.i_wb_we  = we;
        bus.i_wb_dat = dat;
        bus.i_wb_stb = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.o_wb_ack && n < 8);
        chk("ack_latency", 32'(n), 32'd1);
        rd = bus.o_wb_rdt;
        bus.i_wb_stb = 1'b0;
    endtask

    task automatic wr_data(input logic [9:0] dat);
        logic [9:0] rd;
        wb_acc(1'b0, 1'b1, dat, rd);
    endtask

    task automatic rd_status(input string name, input logic [9:0] exp);
        logic [9:0] rd;
        wb_acc(1'b0, 1'b0, 10'd0, rd);
        chk(name, {22'd0, rd}, {22'd0, exp});
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    logic [9:0] rdv;
    int         acks;
    logic [8:0] exp_q[$];

    initial begin
        rst          = 1'b1;
        bus.i_wb_sel = 1'b0;
        bus.i_wb_stb = 1'b0;
        bus.i_wb_we  = 1'b0;
        bus.i_wb_dat = 10'd0;
        bus.i_tready = 1'b0;
        idle(2);
        rst = 1'b0;

        // Reset values
        chk("rst_ack",    {31'd0, bus.o_wb_ack}, 32'd0);
        chk("rst_rdt",    {22'd0, bus.o_wb_rdt}, 32'd0);
        chk("rst_tvalid", {31'd0, bus.o_tvalid}, 32'd0);
        chk("rst_tdata",  {24'd0, bus.o_tdata},  32'd0);
        chk("rst_tlast",  {31'd0, bus.o_tlast},  32'd0);

        // Basic packet A, B, C with tlast on C
        bus.i_tready = 1'b1;
        got.delete();
        wr_data(10'h041);
        wr_data(10'h042);
        wr_data(10'h143);
        idle(4);
        chk("abc_count", 32'(got.size()), 32'd3);
        if (got.size() == 3) begin
            chk("abc_0", {23'd0, got[0]}, 32'h041);
            chk("abc_1", {23'd0, got[1]}, 32'h042);
            chk("abc_2", {23'd0, got[2]}, 32'h143);
        end
        rd_status("status_drained", 10'h080);

        // Overflow with sink stalled
        bus.i_tready = 1'b0;
        got.delete();
        for (int i = 0; i < 5; i++) wr_data(10'(16 + i));
        rd_status("status_ovf_full", 10'h304);
        bus.i_tready = 1'b1;
        idle(8);
        chk("ovf_count", 32'(got.size()), 32'd4);
        for (int i = 0; i < 4 && i < got.size(); i++)
            chk("ovf_order", {23'd0, got[i]}, 32'(16 + i));
        rd_status("status_ovf_empty", 10'h280);

        // Clear OVF, then flush with bytes queued
        wb_acc(1'b1, 1'b1, 10'h001, rdv);
        rd_status("status_ovf_clr", 10'h080);
        bus.i_tready = 1'b0;
        wr_data(10'h0A1);
        wr_data(10'h0A2);
        wr_data(10'h0A3);
        rd_status("status_three", 10'h003);
        wb_acc(1'b1, 1'b1, 10'h002, rdv);
        chk("flush_tvalid", {31'd0, bus.o_tvalid}, 32'd0);
        rd_status("status_flushed", 10'h080);

        // Backpressure toggled every cycle while writing 16 bytes
        got.delete();
        exp_q.delete();
        toggle_en = 1'b1;
        for (int i = 0; i < 16; i++) begin
            logic [9:0] w;
            w = {1'b0, (i % 4 == 3), 8'(8'hB0 + i)};
            exp_q.push_back(w[8:0]);
            wr_data(w);
        end
        toggle_en = 1'b0;
        bus.i_tready = 1'b1;
        idle(8);
        chk("bp_count", 32'(got.size()), 32'd16);
        for (int i = 0; i < 16 && i < got.size(); i++)
            chk("bp_data", {23'd0, got[i]}, {23'd0, exp_q[i]});
        rd_status("status_bp", 10'h080);

        // Strobe held for 6 cycles: one ack, one push
        bus.i_tready = 1'b0;
        @(negedge clk);
        bus.i_wb_sel = 1'b0;
        bus.i_wb_we  = 1'b1;
        bus.i_wb_dat = 10'h077;
        bus.i_wb_stb = 1'b1;
        acks = 0;
        repeat (6) begin
            @(negedge clk);
            if (bus.o_wb_ack) acks++;
        end
        bus.i_wb_stb = 1'b0;
        chk("held_acks", 32'(acks), 32'd1);
        rd_status("status_held", 10'h001);

        // Reset on the accept cycle with two bytes queued
        wr_data(10'h088);
        rd_status("status_two", 10'h002);
        @(negedge clk);
        bus.i_wb_sel = 1'b0;
        bus.i_wb_we  = 1'b1;
        bus.i_wb_dat = 10'h099;
        bus.i_wb_stb = 1'b1;
        rst          = 1'b1;
        @(negedge clk);
        chk("rst_mid_ack",    {31'd0, bus.o_wb_ack}, 32'd0);
        chk("rst_mid_tvalid", {31'd0, bus.o_tvalid}, 32'd0);
        rst          = 1'b0;
        bus.i_wb_stb = 1'b0;
        rd_status("status_after_rst", 10'h080);

        idle(2);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
